// File: rtl/car_lane_ctrl.sv
// -----------------------------------------------------------------------------
// car_lane_ctrl
//
// Player-car control stage fed by the PS/2 keyboard decoder. It turns the
// Enter/Left/Right key levels into single events and runs the game sequence:
// WAIT_START -> READY <-> SLIDING -> CRASHED -> WAIT_START.
// While playing, a Left/Right event slides the car one lane over, one pixel
// every STEP_DIV clocks.
//
// Ports
//   CLOCK_50     in   system clock (50 MHz)
//   reset        in   synchronous, active-high reset
//   enter_key    in   Enter key level from the decoder
//   left_key     in   Left key level from the decoder
//   right_key    in   Right key level from the decoder
//   crash        in   collision level, honoured only while playing
//   lane         out  settled lane index, 0..NUM_LANES-1
//   car_x        out  car x-position in pixels
//   moving       out  high while sliding between lanes
//   game_active  out  high in READY or SLIDING
//   game_over    out  high in CRASHED
//   start_pulse  out  one-cycle pulse when the game starts
// -----------------------------------------------------------------------------
module car_lane_ctrl #(
   parameter int NUM_LANES  = 3,
   parameter int LANE_X0    = 40,
   parameter int LANE_WIDTH = 40,
   parameter int STEP_DIV   = 250000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       enter_key,
   input  logic       left_key,
   input  logic       right_key,
   input  logic       crash,
   output logic [1:0] lane,
   output logic [8:0] car_x,
   output logic       moving,
   output logic       game_active,
   output logic       game_over,
   output logic       start_pulse
);

   localparam int         CENTER    = (NUM_LANES - 1) / 2;
   localparam logic [1:0] LANE_C    = 2'(CENTER);
   localparam logic [1:0] LANE_LAST = 2'(NUM_LANES - 1);
   localparam logic [8:0] X_CENTER  = 9'(LANE_X0 + CENTER * LANE_WIDTH);
   // Prescaler must be at least 1 bit even when STEP_DIV is 1.
   localparam int         PW        = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0] PRESC_TC = PW'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      WAIT_START,
      READY,
      SLIDING,
      CRASHED
   } state_t;

   state_t        state;
   logic          enter_d;
   logic          left_d;
   logic          right_d;
   logic [PW-1:0] presc;
   logic [1:0]    target;
   logic [8:0]    target_x;
   logic          step_up;

   logic          enter_ev;
   logic          left_ev;
   logic          right_ev;
   logic [8:0]    next_x;

   function automatic logic [8:0] lane_x(input logic [1:0] n);
      return 9'(LANE_X0 + int'(n) * LANE_WIDTH);
   endfunction

   // Rising-edge events: a held key yields exactly one event.
   assign enter_ev = enter_key & ~enter_d;
   assign left_ev  = left_key  & ~left_d;
   assign right_ev = right_key & ~right_d;

   always_comb begin
      next_x = car_x;
      if (step_up) next_x = car_x + 9'd1;
      else         next_x = car_x - 9'd1;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state       <= WAIT_START;
         lane        <= LANE_C;
         car_x       <= X_CENTER;
         presc       <= '0;
         target      <= LANE_C;
         target_x    <= X_CENTER;
         step_up     <= 1'b0;
         moving      <= 1'b0;
         game_active <= 1'b0;
         game_over   <= 1'b0;
         start_pulse <= 1'b0;
         enter_d     <= 1'b0;
         left_d      <= 1'b0;
         right_d     <= 1'b0;
      end else begin
         enter_d     <= enter_key;
         left_d      <= left_key;
         right_d     <= right_key;
         start_pulse <= 1'b0;

         case (state)
            WAIT_START: begin
               if (enter_ev) begin
                  state       <= READY;
                  lane        <= LANE_C;
                  car_x       <= X_CENTER;
                  start_pulse <= 1'b1;
                  game_active <= 1'b1;
               end
            end

            READY: begin
               if (crash) begin
                  state       <= CRASHED;
                  game_active <= 1'b0;
                  game_over   <= 1'b1;
               end else if (left_ev && !right_ev && lane != 2'd0) begin
                  state    <= SLIDING;
                  target   <= lane - 2'd1;
                  target_x <= lane_x(lane - 2'd1);
                  step_up  <= 1'b0;
                  presc    <= '0;
                  moving   <= 1'b1;
               end else if (right_ev && !left_ev && lane != LANE_LAST) begin
                  state    <= SLIDING;
                  target   <= lane + 2'd1;
                  target_x <= lane_x(lane + 2'd1);
                  step_up  <= 1'b1;
                  presc    <= '0;
                  moving   <= 1'b1;
               end
            end

            SLIDING: begin
               // Key events are dropped here; only crash and the prescaler act.
               if (crash) begin
                  state       <= CRASHED;
                  moving      <= 1'b0;
                  game_active <= 1'b0;
                  game_over   <= 1'b1;
               end else if (presc == PRESC_TC) begin
                  presc <= '0;
                  car_x <= next_x;
                  // Arriving at the target settles the lane on the same edge.
                  if (next_x == target_x) begin
                     lane   <= target;
                     state  <= READY;
                     moving <= 1'b0;
                  end
               end else begin
                  presc <= presc + PW'(1);
               end
            end

            CRASHED: begin
               if (enter_ev) begin
                  state     <= WAIT_START;
                  lane      <= LANE_C;
                  car_x     <= X_CENTER;
                  game_over <= 1'b0;
               end
            end

            default: state <= WAIT_START;
         endcase
      end
   end

endmodule

// File: tb/tb_car_lane_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_lane_ctrl
//
// Directed scenarios followed by random key/crash/reset traffic. Every cycle
// the DUT outputs are compared with a behavioural model that tracks the game
// phase and derives the slide position from elapsed cycles.
// -----------------------------------------------------------------------------
module tb_car_lane_ctrl;

   localparam int NL = 3;
   localparam int X0 = 40;
   localparam int LW = 40;
   localparam int SD = 2;
   localparam int CTR = (NL - 1) / 2;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic       enter_key = 1'b0;
   logic       left_key = 1'b0;
   logic       right_key = 1'b0;
   logic       crash = 1'b0;
   logic [1:0] lane;
   logic [8:0] car_x;
   logic       moving;
   logic       game_active;
   logic       game_over;
   logic       start_pulse;

   int checks = 0;
   int errors = 0;

   // Model state: phase 0=waiting, 1=ready, 2=sliding, 3=crashed.
   int m_phase = 0;
   int m_lane  = CTR;
   int m_x     = X0 + CTR * LW;
   int m_tgt   = CTR;
   int m_cnt   = 0;
   int m_pulse = 0;
   bit m_pe = 0, m_pl = 0, m_pr = 0;

   car_lane_ctrl #(
      .NUM_LANES(NL), .LANE_X0(X0), .LANE_WIDTH(LW), .STEP_DIV(SD)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .enter_key(enter_key),
      .left_key(left_key), .right_key(right_key), .crash(crash),
      .lane(lane), .car_x(car_x), .moving(moving),
      .game_active(game_active), .game_over(game_over),
      .start_pulse(start_pulse)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int xpos(input int n);
      return X0 + n * LW;
   endfunction

   task automatic model_step(input bit e, input bit l, input bit r,
                             input bit c, input bit rst);
      bit ee, le, re;
      if (rst) begin
         m_phase = 0; m_lane = CTR; m_x = xpos(CTR); m_cnt = 0;
         m_pulse = 0; m_pe = 0; m_pl = 0; m_pr = 0;
         return;
      end
      ee = e && !m_pe; le = l && !m_pl; re = r && !m_pr;
      m_pulse = 0;
      case (m_phase)
         0: if (ee) begin
               m_phase = 1; m_lane = CTR; m_x = xpos(CTR); m_pulse = 1;
            end
         1: if (c) m_phase = 3;
            else if (le && !re && m_lane > 0) begin
               m_phase = 2; m_tgt = m_lane - 1; m_cnt = 0;
            end else if (re && !le && m_lane < NL - 1) begin
               m_phase = 2; m_tgt = m_lane + 1; m_cnt = 0;
            end
         2: if (c) m_phase = 3;
            else begin
               m_cnt++;
               m_x = xpos(m_lane) + ((m_tgt > m_lane) ? 1 : -1) * (m_cnt / SD);
               if (m_cnt == LW * SD) begin
                  m_lane = m_tgt; m_phase = 1;
               end
            end
         3: if (ee) begin
               m_phase = 0; m_lane = CTR; m_x = xpos(CTR);
            end
         default: m_phase = 0;
      endcase
      m_pe = e; m_pl = l; m_pr = r;
   endtask

   // One clock: apply inputs, advance the model at the edge, compare after it.
   task automatic cyc(input bit e, input bit l, input bit r,
                      input bit c, input bit rst);
      enter_key = e; left_key = l; right_key = r; crash = c; reset = rst;
      @(posedge CLOCK_50);
      model_step(e, l, r, c, rst);
      #1;
      chk("lane", int'(lane), m_lane);
      chk("car_x", int'(car_x), m_x);
      chk("moving", int'(moving), int'(m_phase == 2));
      chk("game_active", int'(game_active), int'(m_phase == 1 || m_phase == 2));
      chk("game_over", int'(game_over), int'(m_phase == 3));
      chk("start_pulse", int'(start_pulse), m_pulse);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset, then hold Right while waiting for start.
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk("rst_lane", int'(lane), 1);
      chk("rst_x", int'(car_x), 80);
      chk("rst_active", int'(game_active), 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0);
      chk("wait_lane", int'(lane), 1);
      chk("wait_active", int'(game_active), 0);
      idle(1);

      // Start and slide right to lane 2.
      cyc(1, 0, 0, 0, 0);
      chk("start_pulse_hi", int'(start_pulse), 1);
      cyc(1, 0, 0, 0, 0);
      chk("start_pulse_lo", int'(start_pulse), 0);
      cyc(0, 0, 1, 0, 0);
      chk("slide_moving", int'(moving), 1);
      idle(80);
      chk("slide_lane2", int'(lane), 2);
      chk("slide_x120", int'(car_x), 120);
      chk("slide_done", int'(moving), 0);

      // Edge lane, simultaneous keys, then back to lane 1.
      cyc(0, 0, 1, 0, 0); idle(3);
      cyc(0, 1, 1, 0, 0); idle(3);
      chk("ignored_x", int'(car_x), 120);
      cyc(0, 1, 0, 0, 0); idle(80);
      chk("back_x80", int'(car_x), 80);

      // Second Left mid-slide is dropped.
      cyc(0, 1, 0, 0, 0); idle(5);
      cyc(0, 1, 0, 0, 0); idle(100);
      chk("dbl_left_lane", int'(lane), 0);

      // Back to lane 1, then crash mid-slide at x=100.
      cyc(0, 0, 1, 0, 0); idle(80);
      cyc(0, 0, 1, 0, 0); idle(40);
      chk("pre_crash_x", int'(car_x), 100);
      cyc(0, 0, 0, 1, 0);
      chk("crash_over", int'(game_over), 1);
      chk("crash_x", int'(car_x), 100);
      chk("crash_lane", int'(lane), 1);
      idle(2);
      cyc(1, 0, 0, 0, 0);
      chk("restart_x", int'(car_x), 80);
      idle(1);
      cyc(1, 0, 0, 0, 0); idle(1);
      cyc(0, 0, 1, 1, 0);
      chk("crash_prio_mv", int'(moving), 0);
      chk("crash_prio_over", int'(game_over), 1);

      // Reset mid-slide at x=95.
      cyc(1, 0, 0, 0, 0); idle(1);
      cyc(1, 0, 0, 0, 0); idle(1);
      cyc(0, 0, 1, 0, 0); idle(30);
      chk("pre_rst_x", int'(car_x), 95);
      cyc(0, 0, 0, 0, 1);
      chk("midrst_x", int'(car_x), 80);
      chk("midrst_mv", int'(moving), 0);
      chk("midrst_active", int'(game_active), 0);

      // Random traffic.
      for (int i = 0; i < 6000; i++)
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
             $urandom_range(0, 5) == 0, $urandom_range(0, 149) == 0,
             $urandom_range(0, 599) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
